fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Parametrised successor to the fixed 4-byte instruction-register load in the TinyMIPS multicycle datapath. It autonomously fetches one INSTR_W-bit instruction from DATA_W-wide memory over BYTES = INSTR_W/DATA_W transfers and advances its own PC. Memory responses may stall via a valid handshake, and branch/jump redirects are supported. It sits between memory and the datapath instruction path, replacing the controller-driven irwrite/iord byte sequencing.

Parameters:
DATA_W, 8, memory data width in bits (one byte-lane).
INSTR_W, 32, instruction width; INSTR_W % DATA_W != 0 is an elaboration error.
ADDR_W, 8, address/PC width; PC wraps modulo 2^ADDR_W.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
fetch_en  in  1  permit fetching; sampled in IDLE and on consume.
memdata  in  DATA_W  byte returned by memory.
mem_valid  in  1  memdata valid this cycle; ignored when mem_req=0.
mem_req  out  1  byte request outstanding at address adr.
adr  out  ADDR_W  memory byte address (equals pc).
instr  out  INSTR_W  assembled instruction; meaningful only when instr_valid=1.
instr_valid  out  1  complete instruction held.
instr_ack  in  1  consumer accepts instr (handshake with instr_valid).
redirect  in  1  load new PC, abort current fetch.
redirect_pc  in  ADDR_W  target for redirect.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any time including mid-fetch): state=IDLE, pc=RESET_PC, lane count=0, instr=0, instr_valid=0, mem_req=0, adr=RESET_PC, busy=0.
- States: IDLE, FETCH, DONE. Registered state; outputs decoded from state/registers (no combinational path from inputs to mem_req/instr_valid).
- IDLE: mem_req=0. fetch_en=1 -> FETCH next cycle.
- FETCH: mem_req=1, adr=pc. mem_valid=1 -> memdata written to instr[cnt*DATA_W +: DATA_W] (little-endian, first byte = least-significant lane), pc<=pc+1, cnt<=cnt+1. When the byte is accepted with cnt==BYTES-1: cnt<=0, state -> DONE. mem_valid=0 -> hold everything (wait state, unbounded).
- Lanes not yet written in the current fetch retain the previous instruction's bytes.
- DONE: instr_valid=1, mem_req=0, instr stable. instr_ack=1 -> instr_valid drops next cycle; next state FETCH if fetch_en=1, else IDLE. Back-to-back fetch therefore costs one DONE cycle minimum; minimum fetch latency = BYTES cycles from FETCH entry to DONE.
- instr_ack outside DONE is ignored.
- redirect=1 (any state, priority over all except reset): pc<=redirect_pc, cnt<=0, instr_valid<=0, next state FETCH if fetch_en=1 else IDLE. A memdata byte with mem_valid in the same cycle is discarded. An instruction in DONE is dropped even if instr_ack is also 1.
- fetch_en deasserted during FETCH does not abort; the current instruction completes to DONE.
- PC increment and redirect wrap naturally at ADDR_W bits (0xFF+1 -> 0x00 at ADDR_W=8).

Decomposition:
- Shared package tinymips_pkg: state enumeration (IDLE/FETCH/DONE), default DATA_W/INSTR_W/ADDR_W constants, derived BYTES helper.
- One natural sub-module: byte_lane_reg, a DATA_W-wide enabled register with async reset, instantiated BYTES times via generate (generalisation of the existing four per-byte enable flops).

Test Plan:
- Reset release, fetch_en=1, memory returns 0x20,0x08,0x43,0x00 on mem_valid each cycle at adr 0,1,2,3 -> instr=0x00430820, instr_valid=1 in the cycle after the 4th byte, adr=4.
- Same fetch with mem_valid low for 3 cycles before byte 2 -> adr holds at 1, mem_req stays 1, result identical, instr_valid delayed 3 cycles.
- RESET_PC=0xFE -> request addresses 0xFE,0xFF,0x00,0x01; pc=0x02 after DONE.
- Redirect to 0x40 after byte 2, same cycle as mem_valid -> that byte discarded, next request at 0x40, instr_valid stays 0 until 4 new bytes arrive.
- fetch_en held, instr_ack asserted on first DONE cycle -> second fetch begins at adr 4 next cycle; redirect with instr_ack in DONE -> instruction dropped, fetch restarts at redirect_pc.
- Assert reset during byte 3 -> all outputs return to reset values immediately (async), pc=RESET_PC; DATA_W=16/INSTR_W=32 build fetches in 2 transfers.

Source files
------------

// File: rtl/tinymips_pkg.sv
// Shared types and default widths for the TinyMIPS instruction fetch path.
// Holds the sequencer state encoding and the lanes-per-instruction helper.
package tinymips_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    function automatic int lanes_per_instr(input int instr_w, input int data_w);
        return instr_w / data_w;
    endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// One DATA_W-wide lane of the instruction register; loads on en_i, holds otherwise.
// Single-cycle write latency, no backpressure (the caller decides when to enable).
module byte_lane_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] lane_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
        end else if (en_i) begin
            lane_q <= d_i;
        end
    end

    assign q_o = lane_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches one INSTR_W instruction as BYTES little-endian DATA_W transfers; BYTES cycles minimum.
// Memory stalls via mem_valid; a held instruction waits in DONE until instr_ack.
module fetch_sequencer
    import tinymips_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic [DATA_W-1:0]  memdata,
    input  logic               mem_valid,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  adr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ack,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               busy
);

    localparam int               BYTES    = lanes_per_instr(INSTR_W, DATA_W);
    localparam int               CNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    if (INSTR_W % DATA_W != 0) begin : g_bad_width
        $error("fetch_sequencer: INSTR_W must be a multiple of DATA_W");
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byte_acc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        byte_acc = 1'b0;
        if (redirect) begin
            // Redirect wins over everything: an in-flight byte or a held instruction is dropped.
            pc_d    = redirect_pc;
            cnt_d   = '0;
            state_d = fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fetch_en) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_valid) begin
                        byte_acc = 1'b1;
                        pc_d     = pc_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (instr_ack) begin
                        state_d = fetch_en ? ST_FETCH : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unwritten lanes keep the previous instruction's bytes until overwritten.
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic lane_en;
        assign lane_en = byte_acc && (cnt_q == CNT_W'(i));
        byte_lane_reg #(.DATA_W(DATA_W)) u_lane (
            .clk  (clk),
            .rst  (reset),
            .en_i (lane_en),
            .d_i  (memdata),
            .q_o  (instr[i*DATA_W +: DATA_W])
        );
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign adr         = pc_q;

endmodule
